// File: rtl/ddr3_ctrl_pkg.sv
// Constants and types shared by the DDR3 memory controller and the
// logic around its single user port.
package ddr3_ctrl_pkg;

  // Default user-side widths: 3 bank bits plus 15 row/column bits, 8-bit data.
  localparam int DEFAULT_ADDRESS_BITWIDTH = 18;
  localparam int DEFAULT_DQ_BITWIDTH      = 8;
  localparam int DEFAULT_STATE_BITWIDTH   = 5;

  // Controller main_state values in which a user write / read is taken.
  localparam int CTRL_STATE_WRITE_DATA = 8;
  localparam int CTRL_STATE_READ_DATA  = 11;

  // User-port arbiter states.
  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_ISSUE   = 2'd1,
    ARB_WAIT_RD = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: grants the first valid requester found
// scanning upward from the one after rr_ptr_i, wrapping modulo NUM_REQ.
module rr_priority_picker #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_valid_i,
  input  logic [IDX_W-1:0]   rr_ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDX_W-1:0]   grant_idx_o,
  output logic               grant_any_o
);

  // First-hit scan from rr_ptr_i+1; later hits are ignored once one is found.
  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    grant_any_o = 1'b0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      logic [IDX_W-1:0] cand;
      cand = IDX_W'((int'(rr_ptr_i) + off) % NUM_REQ);
      if (!grant_any_o && req_valid_i[cand]) begin
        grant_any_o   = 1'b1;
        grant_o[cand] = 1'b1;
        grant_idx_o   = cand;
      end
    end
  end

endmodule

// File: rtl/ddr3_user_port_arbiter.sv
// Shares the controller's single user port among NUM_REQ requesters.
// Round-robin grant, one transaction in flight, enables held until the
// controller's main_state shows it took the access, read data returned to
// the owning requester READ_LATENCY+1 cycles after the read was accepted.
module ddr3_user_port_arbiter
  import ddr3_ctrl_pkg::*;
#(
  parameter int NUM_REQ          = 2,
  parameter int ADDRESS_BITWIDTH = DEFAULT_ADDRESS_BITWIDTH,
  parameter int DQ_BITWIDTH      = DEFAULT_DQ_BITWIDTH,
  parameter int STATE_BITWIDTH   = DEFAULT_STATE_BITWIDTH,
  parameter int STATE_WRITE_DATA = CTRL_STATE_WRITE_DATA,
  parameter int STATE_READ_DATA  = CTRL_STATE_READ_DATA,
  parameter int READ_LATENCY     = 4
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [NUM_REQ-1:0]                  req_valid,
  input  logic [NUM_REQ-1:0]                  req_write,
  input  logic [NUM_REQ*ADDRESS_BITWIDTH-1:0] req_address,
  input  logic [NUM_REQ*DQ_BITWIDTH-1:0]      req_wdata,
  output logic [NUM_REQ-1:0]                  req_ready,
  output logic [NUM_REQ-1:0]                  rsp_valid,
  output logic [DQ_BITWIDTH-1:0]              rsp_data,
  output logic                                busy,
  output logic                                write_enable,
  output logic                                read_enable,
  output logic [ADDRESS_BITWIDTH-1:0]         i_user_data_address,
  output logic [DQ_BITWIDTH-1:0]              data_to_ram,
  input  logic [DQ_BITWIDTH-1:0]              data_from_ram,
  input  logic [STATE_BITWIDTH-1:0]           main_state
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = 4;

  localparam logic [STATE_BITWIDTH-1:0] WR_ACCEPT = STATE_BITWIDTH'(STATE_WRITE_DATA);
  localparam logic [STATE_BITWIDTH-1:0] RD_ACCEPT = STATE_BITWIDTH'(STATE_READ_DATA);
  localparam logic [CNT_W-1:0]          LAT_LOAD  = CNT_W'(READ_LATENCY);
  localparam logic [IDX_W-1:0]          PTR_RESET = IDX_W'(NUM_REQ - 1);

  arb_state_e                  state_q, state_d;
  logic [IDX_W-1:0]            rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [NUM_REQ-1:0]          rsp_valid_q, rsp_valid_d;
  logic [DQ_BITWIDTH-1:0]      rsp_data_q, rsp_data_d;

  // Captured transaction; only meaningful while busy, so not reset.
  logic [IDX_W-1:0]            owner_q, owner_d;
  logic                        wr_q, wr_d;
  logic [ADDRESS_BITWIDTH-1:0] addr_q, addr_d;
  logic [DQ_BITWIDTH-1:0]      wdata_q, wdata_d;

  logic [NUM_REQ-1:0]          pick_gnt;
  logic [IDX_W-1:0]            pick_idx;
  logic                        pick_any;

  rr_priority_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req_valid_i (req_valid),
    .rr_ptr_i    (rr_ptr_q),
    .grant_o     (pick_gnt),
    .grant_idx_o (pick_idx),
    .grant_any_o (pick_any)
  );

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;

  // Next-state and port outputs; all outputs idle unless the state drives them.
  always_comb begin
    state_d             = state_q;
    rr_ptr_d            = rr_ptr_q;
    cnt_d               = cnt_q;
    rsp_valid_d         = '0;
    rsp_data_d          = rsp_data_q;
    owner_d             = owner_q;
    wr_d                = wr_q;
    addr_d              = addr_q;
    wdata_d             = wdata_q;
    req_ready           = '0;
    busy                = 1'b0;
    write_enable        = 1'b0;
    read_enable         = 1'b0;
    i_user_data_address = '0;
    data_to_ram         = '0;

    case (state_q)
      ARB_IDLE: begin
        // A grant shown during reset would never be captured, so hide it.
        if (pick_any && !reset) begin
          req_ready = pick_gnt;
          owner_d   = pick_idx;
          wr_d      = req_write[pick_idx];
          addr_d    = req_address[pick_idx*ADDRESS_BITWIDTH +: ADDRESS_BITWIDTH];
          wdata_d   = req_wdata[pick_idx*DQ_BITWIDTH +: DQ_BITWIDTH];
          rr_ptr_d  = pick_idx;
          state_d   = ARB_ISSUE;
        end
      end

      ARB_ISSUE: begin
        busy                = 1'b1;
        write_enable        = wr_q;
        read_enable         = !wr_q;
        i_user_data_address = addr_q;
        data_to_ram         = wr_q ? wdata_q : '0;
        if (wr_q && main_state == WR_ACCEPT) begin
          state_d = ARB_IDLE;
        end else if (!wr_q && main_state == RD_ACCEPT) begin
          cnt_d   = LAT_LOAD;
          state_d = ARB_WAIT_RD;
        end
      end

      ARB_WAIT_RD: begin
        busy  = 1'b1;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q <= CNT_W'(1)) begin
          rsp_valid_d[owner_q] = 1'b1;
          rsp_data_d           = data_from_ram;
          cnt_d                = '0;
          state_d              = ARB_IDLE;
        end
      end

      default: state_d = ARB_IDLE;
    endcase
  end

  // Control state and response registers; reset drops any transaction in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ARB_IDLE;
      rr_ptr_q    <= PTR_RESET;
      cnt_q       <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  // Captured request payload.
  always_ff @(posedge clk) begin
    owner_q <= owner_d;
    wr_q    <= wr_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
  end

endmodule

// File: tb/tb_ddr3_user_port_arbiter.sv
// Directed bench for ddr3_user_port_arbiter with two requesters.
module tb_ddr3_user_port_arbiter;

  localparam int NR = 2;
  localparam int AW = 18;
  localparam int DW = 8;
  localparam int SW = 5;

  logic             clk = 1'b0;
  logic             reset;
  logic [NR-1:0]    req_valid;
  logic [NR-1:0]    req_write;
  logic [NR*AW-1:0] req_address;
  logic [NR*DW-1:0] req_wdata;
  logic [NR-1:0]    req_ready;
  logic [NR-1:0]    rsp_valid;
  logic [DW-1:0]    rsp_data;
  logic             busy;
  logic             write_enable;
  logic             read_enable;
  logic [AW-1:0]    i_user_data_address;
  logic [DW-1:0]    data_to_ram;
  logic [DW-1:0]    data_from_ram;
  logic [SW-1:0]    main_state;

  ddr3_user_port_arbiter dut (
    .clk                 (clk),
    .reset               (reset),
    .req_valid           (req_valid),
    .req_write           (req_write),
    .req_address         (req_address),
    .req_wdata           (req_wdata),
    .req_ready           (req_ready),
    .rsp_valid           (rsp_valid),
    .rsp_data            (rsp_data),
    .busy                (busy),
    .write_enable        (write_enable),
    .read_enable         (read_enable),
    .i_user_data_address (i_user_data_address),
    .data_to_ram         (data_to_ram),
    .data_from_ram       (data_from_ram),
    .main_state          (main_state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Event monitor sampled on the falling edge.
  int both_en   = 0;
  int rsp_cnt   = 0;
  int ready_cnt = 0;
  int glog[$];
  bit log_en = 1'b0;

  always @(negedge clk) begin
    if (write_enable && read_enable) both_en++;
    if (rsp_valid != '0) rsp_cnt++;
    if (req_ready != '0) begin
      ready_cnt++;
      if (log_en) glog.push_back(req_ready[1] ? 1 : 0);
    end
  end

  logic [DW-1:0] mem_model [4];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(input int r, input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (req_ready == '0 && n < 20) begin
      step();
      @(negedge clk);
      n++;
    end
    check_eq(tag, 32'(req_ready), 32'(1) << r);
    step();
    req_valid[r] = 1'b0;
  endtask

  task automatic do_write(input int r, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[r]               = 1'b1;
    req_write[r]               = 1'b1;
    req_address[r*AW +: AW]    = a;
    req_wdata[r*DW +: DW]      = d;
    wait_grant(r, "lb_wr_grant");
    main_state = 5'd8;
    @(negedge clk);
    check_eq("lb_wr_en", 32'(write_enable), 32'd1);
    mem_model[a[1:0]] = data_to_ram;
    step();
    main_state = 5'd0;
  endtask

  task automatic do_read(input int r, input logic [AW-1:0] a, input logic [DW-1:0] exp);
    req_valid[r]            = 1'b1;
    req_write[r]            = 1'b0;
    req_address[r*AW +: AW] = a;
    wait_grant(r, "lb_rd_grant");
    main_state = 5'd11;
    @(negedge clk);
    check_eq("lb_rd_en", 32'(read_enable), 32'd1);
    step();
    main_state = 5'd0;
    repeat (3) step();
    data_from_ram = mem_model[a[1:0]];
    step();
    data_from_ram = 8'hEE;
    @(negedge clk);
    check_eq("lb_rsp_valid", 32'(rsp_valid), 32'(1) << r);
    check_eq("lb_rsp_data", 32'(rsp_data), 32'(exp));
    step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base_rsp, base_rdy, bad;

    reset         = 1'b1;
    req_valid     = 2'b11;
    req_write     = '0;
    req_address   = '0;
    req_wdata     = '0;
    data_from_ram = '0;
    main_state    = '0;
    repeat (2) step();

    // Reset state, with requests pending that must not be shown ready.
    @(negedge clk);
    check_eq("rst_ready", 32'(req_ready), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_we", 32'(write_enable), 32'd0);
    check_eq("rst_re", 32'(read_enable), 32'd0);
    check_eq("rst_addr", 32'(i_user_data_address), 32'd0);
    check_eq("rst_wdata", 32'(data_to_ram), 32'd0);
    check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("rst_rsp_data", 32'(rsp_data), 32'd0);
    step();
    req_valid = '0;
    reset     = 1'b0;
    step();

    // Single write: accepted on the 4th ISSUE cycle.
    base_rsp = rsp_cnt;
    base_rdy = ready_cnt;
    req_valid[0]       = 1'b1;
    req_write[0]       = 1'b1;
    req_address[0 +: AW] = 18'h00005;
    req_wdata[0 +: DW]   = 8'hA5;
    @(negedge clk);
    check_eq("wr_ready", 32'(req_ready), 32'd1);
    check_eq("wr_idle_we", 32'(write_enable), 32'd0);
    step();
    req_valid = '0;
    for (int k = 0; k < 4; k++) begin
      main_state = (k == 3) ? 5'd8 : 5'd0;
      @(negedge clk);
      check_eq("wr_we", 32'(write_enable), 32'd1);
      check_eq("wr_re", 32'(read_enable), 32'd0);
      check_eq("wr_addr", 32'(i_user_data_address), 32'h5);
      check_eq("wr_data", 32'(data_to_ram), 32'hA5);
      check_eq("wr_busy", 32'(busy), 32'd1);
      step();
    end
    main_state = 5'd0;
    @(negedge clk);
    check_eq("wr_we_drop", 32'(write_enable), 32'd0);
    check_eq("wr_busy_drop", 32'(busy), 32'd0);
    check_eq("wr_ready_pulses", 32'(ready_cnt - base_rdy), 32'd1);
    check_eq("wr_no_rsp", 32'(rsp_cnt - base_rsp), 32'd0);
    step();

    // Single read by requester 1: response 5 cycles after accept.
    req_valid[1]          = 1'b1;
    req_write[1]          = 1'b0;
    req_address[AW +: AW] = 18'h00005;
    data_from_ram         = 8'h5A;
    @(negedge clk);
    check_eq("rd_ready", 32'(req_ready), 32'd2);
    step();
    req_valid  = '0;
    main_state = 5'd11;
    @(negedge clk);
    check_eq("rd_re", 32'(read_enable), 32'd1);
    check_eq("rd_we", 32'(write_enable), 32'd0);
    check_eq("rd_data_to_ram", 32'(data_to_ram), 32'd0);
    check_eq("rd_addr", 32'(i_user_data_address), 32'h5);
    step();
    main_state = 5'd0;
    repeat (3) begin
      @(negedge clk);
      check_eq("rd_wait_rsp", 32'(rsp_valid), 32'd0);
      check_eq("rd_wait_busy", 32'(busy), 32'd1);
      check_eq("rd_wait_re", 32'(read_enable), 32'd0);
      step();
    end
    data_from_ram = 8'hA5;
    step();
    data_from_ram = 8'h33;
    @(negedge clk);
    check_eq("rd_rsp_valid", 32'(rsp_valid), 32'd2);
    check_eq("rd_rsp_data", 32'(rsp_data), 32'hA5);
    check_eq("rd_rsp_busy", 32'(busy), 32'd0);
    step();
    @(negedge clk);
    check_eq("rd_rsp_pulse", 32'(rsp_valid), 32'd0);
    check_eq("rd_rsp_hold", 32'(rsp_data), 32'hA5);
    step();

    // Contention after reset: grants alternate starting with requester 0.
    reset = 1'b1;
    step();
    reset       = 1'b0;
    req_valid   = 2'b11;
    req_write   = 2'b11;
    main_state  = 5'd8;
    glog.delete();
    log_en      = 1'b1;
    for (int n = 0; n < 40 && glog.size() < 4; n++) step();
    log_en    = 1'b0;
    req_valid = '0;
    check_eq("cont_count", 32'(glog.size() >= 4), 32'd1);
    if (glog.size() >= 4) begin
      check_eq("cont_g0", 32'(glog[0]), 32'd0);
      check_eq("cont_g1", 32'(glog[1]), 32'd1);
      check_eq("cont_g2", 32'(glog[2]), 32'd0);
      check_eq("cont_g3", 32'(glog[3]), 32'd1);
    end
    repeat (2) step();
    main_state = 5'd0;
    step();

    // Refresh stall: write held 200 cycles while requester 1 waits.
    base_rdy             = ready_cnt;
    req_valid            = 2'b01;
    req_write            = 2'b11;
    req_address[0 +: AW] = 18'h01234;
    req_wdata[0 +: DW]   = 8'h3C;
    main_state           = 5'd3;
    @(negedge clk);
    check_eq("stall_ready", 32'(req_ready), 32'd1);
    step();
    req_valid = 2'b10;
    bad = 0;
    repeat (200) begin
      @(negedge clk);
      if (write_enable !== 1'b1 || read_enable !== 1'b0 || i_user_data_address !== 18'h01234 ||
          data_to_ram !== 8'h3C || busy !== 1'b1 || req_ready !== 2'b00) bad++;
      step();
    end
    check_eq("stall_stable", 32'(bad), 32'd0);
    main_state = 5'd8;
    @(negedge clk);
    check_eq("stall_accept_we", 32'(write_enable), 32'd1);
    step();
    req_valid  = '0;
    main_state = 5'd0;
    @(negedge clk);
    check_eq("stall_done_we", 32'(write_enable), 32'd0);
    check_eq("stall_done_busy", 32'(busy), 32'd0);
    check_eq("stall_grants", 32'(ready_cnt - base_rdy), 32'd1);
    step();

    // Loopback: data i to address i, read back alternating requesters.
    for (int i = 0; i < 4; i++) do_write(0, AW'(i), DW'(i));
    for (int i = 0; i < 4; i++) do_read(i % 2, AW'(i), DW'(i));

    // Reset during WAIT_RD; last grant went to requester 1.
    req_valid[0]         = 1'b1;
    req_write[0]         = 1'b0;
    req_address[0 +: AW] = 18'h00007;
    @(negedge clk);
    check_eq("rr_ready_pre", 32'(req_ready), 32'd1);
    step();
    req_valid  = '0;
    main_state = 5'd11;
    step();
    main_state = 5'd0;
    step();
    reset = 1'b1;
    step();
    reset    = 1'b0;
    base_rsp = rsp_cnt;
    @(negedge clk);
    check_eq("rr_busy", 32'(busy), 32'd0);
    check_eq("rr_we", 32'(write_enable), 32'd0);
    check_eq("rr_re", 32'(read_enable), 32'd0);
    check_eq("rr_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("rr_rsp_data", 32'(rsp_data), 32'd0);
    repeat (8) step();
    check_eq("rr_no_rsp", 32'(rsp_cnt - base_rsp), 32'd0);
    req_valid = 2'b11;
    req_write = 2'b11;
    @(negedge clk);
    check_eq("rr_first_grant", 32'(req_ready), 32'd1);
    step();
    req_valid  = '0;
    main_state = 5'd8;
    step();
    main_state = 5'd0;
    step();

    check_eq("never_both_en", 32'(both_en), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
